alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one ALU instance between two requesters (e.g. the EX stage and a secondary execution client) using a valid/ready request handshake and round-robin arbitration. It latches the winning operands and control code, drives them onto the shared ALU for a fixed number of cycles, and returns the registered result to the owning requester with a one-cycle valid pulse. MUL (ctrl 3'b011) is held for a configurable multi-cycle latency; all other codes take one cycle.

## Interface
- MUL_LAT, default 3: cycles ALU inputs are held for MUL; legal range 1..15.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req0_valid_i  in  1  requester 0 has an operation pending.
- req0_ready_o  out  1  requester 0 operation accepted this cycle when valid&ready.
- req0_data1_i, req0_data2_i  in  32 each  requester 0 operands (signed).
- req0_ctrl_i  in  3  requester 0 ALU code: 000 AND, 001 XOR, 010 ADD, 110 SUB, 111 SLL, 101 SRA, 011 MUL, 100 OR.
- req1_valid_i, req1_ready_o, req1_data1_i, req1_data2_i, req1_ctrl_i: same for requester 1.
- resp0_valid_o  out  1  one-cycle pulse: result for requester 0.
- resp0_data_o  out  32  result for requester 0.
- resp0_zero_o  out  1  1 when resp0_data_o == 0.
- resp1_valid_o, resp1_data_o, resp1_zero_o: same for requester 1.
- alu_data1_o, alu_data2_o  out  32 each  operands to shared ALU.
- alu_ctrl_o  out  3  control code to shared ALU.
- alu_data_i  in  32  combinational result from shared ALU.

## Operation
- States: IDLE, EXEC.
- IDLE: grant chosen combinationally. Only one valid -> grant it. Both valid -> grant requester != last_grant. reqN_ready_o = (state==IDLE) & grant==N & reqN_valid_i; never both high.
- Handshake (valid&ready at edge): latch data1, data2, ctrl into operand regs, owner <= N, last_grant <= N, cnt <= (ctrl==011) ? MUL_LAT : 1, state <= EXEC.
- EXEC: alu_*_o driven from operand regs (stable whole op). Each edge cnt decrements; at edge with cnt==1: resp data reg <= alu_data_i, zero reg <= (alu_data_i==0), respN_valid_o <= 1 for owner only, state <= IDLE.
- respN_valid_o high exactly one cycle; no response backpressure. respN_data_o/zero_o hold until next completion for that requester.
- alu_*_o hold last operands while IDLE.
- Requester may drop valid before handshake; no penalty, arbitration re-evaluated each IDLE cycle. Inputs ignored outside IDLE.
- Arithmetic/width: block passes operands unmodified; result taken as full 32 bits from alu_data_i.
- Reset values: state IDLE, last_grant=1 (req0 wins first tie), operand regs 0, alu_ctrl_o 000, cnt 0, all resp*_valid_o 0, resp*_data_o 0, resp*_zero_o 0, ready outputs 0 unless IDLE logic grants.
- Reset mid-EXEC: op aborted, no response pulse after reset release.

## Timing
- Accept at edge A. Non-MUL: result captured at edge A+1, respN_valid_o high during cycle A+1..A+2. MUL: capture at edge A+MUL_LAT.
- Minimum issue interval: 2 cycles non-MUL, MUL_LAT+1 cycles MUL (ready low while EXEC and in the cycle state returns... ready high in the cycle after completion edge).
- readyN_o is combinational from state, last_grant, both valids; no combinational path from alu_data_i to any output.
- Back-to-back contention with both valid continuously: grants alternate 0,1,0,1.

## Test plan
- Single ADD: req0 valid, data1=5, data2=7, ctrl=010 -> ready0 same cycle, resp0_valid 1 cycle later, data 12, zero 0; resp1_valid stays 0.
- SUB to zero: req1 data1=9, data2=9, ctrl=110 -> resp1_data 0, resp1_zero 1.
- MUL latency, MUL_LAT=3: req0 data1=-3, data2=4, ctrl=011 -> alu_*_o stable 3 cycles, resp0_data 0xFFFFFFF4 exactly 3 cycles after accept; no ready during EXEC.
- Round-robin: both valid continuously, 4 ADD ops -> grant order 0,1,0,1 after reset; never both ready high.
- Reset mid-MUL: assert rst_i during EXEC cycle 2 -> all outputs reset immediately, no resp pulse after release, next request serviced normally.
- Valid withdrawal: req1 valid one cycle while busy, then drops -> never accepted, no resp1 pulse.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
//==============================================================================
// Module : alu_arbiter
// Brief  : Round-robin arbiter sharing one combinational ALU between two
//          valid/ready requesters, with a configurable multi-cycle MUL hold.
// Rev    : 1.0  initial release
//==============================================================================
module alu_arbiter #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_data1_i,
    input  logic [31:0] req0_data2_i,
    input  logic [2:0]  req0_ctrl_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_data1_i,
    input  logic [31:0] req1_data2_i,
    input  logic [2:0]  req1_ctrl_i,

    output logic        resp0_valid_o,
    output logic [31:0] resp0_data_o,
    output logic        resp0_zero_o,

    output logic        resp1_valid_o,
    output logic [31:0] resp1_data_o,
    output logic        resp1_zero_o,

    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    output logic [2:0]  alu_ctrl_o,
    input  logic [31:0] alu_data_i
);

    localparam logic [2:0] c_CTRL_MUL = 3'b011;
    localparam logic [3:0] c_CNT_MUL  = 4'(MUL_LAT);
    localparam logic [3:0] c_CNT_ONE  = 4'd1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t      r_state_q,       w_state_d;
    logic        r_last_grant_q,  w_last_grant_d;
    logic        r_owner_q,       w_owner_d;
    logic [3:0]  r_cnt_q,         w_cnt_d;
    logic [31:0] r_op1_q,         w_op1_d;
    logic [31:0] r_op2_q,         w_op2_d;
    logic [2:0]  r_ctrl_q,        w_ctrl_d;

    logic        r_resp0_valid_q, w_resp0_valid_d;
    logic [31:0] r_resp0_data_q,  w_resp0_data_d;
    logic        r_resp0_zero_q,  w_resp0_zero_d;
    logic        r_resp1_valid_q, w_resp1_valid_d;
    logic [31:0] r_resp1_data_q,  w_resp1_data_d;
    logic        r_resp1_zero_q,  w_resp1_zero_d;

    logic        w_grant;
    logic        w_idle;
    logic        w_ready0;
    logic        w_ready1;
    logic        w_accept;
    logic [31:0] w_sel_op1;
    logic [31:0] w_sel_op2;
    logic [2:0]  w_sel_ctrl;
    logic        w_done;
    logic        w_res_zero;

    // Grant index: on contention the requester that did not win last time goes.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            w_grant = ~r_last_grant_q;
        end else if (req1_valid_i) begin
            w_grant = 1'b1;
        end
    end

    assign w_idle   = (r_state_q == S_IDLE);
    assign w_ready0 = w_idle & req0_valid_i & ~w_grant;
    assign w_ready1 = w_idle & req1_valid_i &  w_grant;
    assign w_accept = w_ready0 | w_ready1;

    assign w_sel_op1  = w_grant ? req1_data1_i : req0_data1_i;
    assign w_sel_op2  = w_grant ? req1_data2_i : req0_data2_i;
    assign w_sel_ctrl = w_grant ? req1_ctrl_i  : req0_ctrl_i;

    assign w_done     = (r_state_q == S_EXEC) && (r_cnt_q == c_CNT_ONE);
    assign w_res_zero = (alu_data_i == 32'd0);

    always_comb begin
        w_state_d       = r_state_q;
        w_last_grant_d  = r_last_grant_q;
        w_owner_d       = r_owner_q;
        w_cnt_d         = r_cnt_q;
        w_op1_d         = r_op1_q;
        w_op2_d         = r_op2_q;
        w_ctrl_d        = r_ctrl_q;
        w_resp0_valid_d = 1'b0;
        w_resp0_data_d  = r_resp0_data_q;
        w_resp0_zero_d  = r_resp0_zero_q;
        w_resp1_valid_d = 1'b0;
        w_resp1_data_d  = r_resp1_data_q;
        w_resp1_zero_d  = r_resp1_zero_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    w_op1_d        = w_sel_op1;
                    w_op2_d        = w_sel_op2;
                    w_ctrl_d       = w_sel_ctrl;
                    w_owner_d      = w_grant;
                    w_last_grant_d = w_grant;
                    w_cnt_d        = (w_sel_ctrl == c_CTRL_MUL) ? c_CNT_MUL : c_CNT_ONE;
                    w_state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                w_cnt_d = r_cnt_q - c_CNT_ONE;
                if (w_done) begin
                    // Only the owner's result registers move; the other side holds.
                    if (r_owner_q) begin
                        w_resp1_valid_d = 1'b1;
                        w_resp1_data_d  = alu_data_i;
                        w_resp1_zero_d  = w_res_zero;
                    end else begin
                        w_resp0_valid_d = 1'b1;
                        w_resp0_data_d  = alu_data_i;
                        w_resp0_zero_d  = w_res_zero;
                    end
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q       <= S_IDLE;
            r_last_grant_q  <= 1'b1;
            r_owner_q       <= 1'b0;
            r_cnt_q         <= 4'd0;
            r_op1_q         <= 32'd0;
            r_op2_q         <= 32'd0;
            r_ctrl_q        <= 3'd0;
            r_resp0_valid_q <= 1'b0;
            r_resp0_data_q  <= 32'd0;
            r_resp0_zero_q  <= 1'b0;
            r_resp1_valid_q <= 1'b0;
            r_resp1_data_q  <= 32'd0;
            r_resp1_zero_q  <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_last_grant_q  <= w_last_grant_d;
            r_owner_q       <= w_owner_d;
            r_cnt_q         <= w_cnt_d;
            r_op1_q         <= w_op1_d;
            r_op2_q         <= w_op2_d;
            r_ctrl_q        <= w_ctrl_d;
            r_resp0_valid_q <= w_resp0_valid_d;
            r_resp0_data_q  <= w_resp0_data_d;
            r_resp0_zero_q  <= w_resp0_zero_d;
            r_resp1_valid_q <= w_resp1_valid_d;
            r_resp1_data_q  <= w_resp1_data_d;
            r_resp1_zero_q  <= w_resp1_zero_d;
        end
    end

    assign req0_ready_o  = w_ready0;
    assign req1_ready_o  = w_ready1;

    assign resp0_valid_o = r_resp0_valid_q;
    assign resp0_data_o  = r_resp0_data_q;
    assign resp0_zero_o  = r_resp0_zero_q;
    assign resp1_valid_o = r_resp1_valid_q;
    assign resp1_data_o  = r_resp1_data_q;
    assign resp1_zero_o  = r_resp1_zero_q;

    assign alu_data1_o   = r_op1_q;
    assign alu_data2_o   = r_op2_q;
    assign alu_ctrl_o    = r_ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
//==============================================================================
// Module : tb_alu_arbiter
// Brief  : Randomised scoreboard bench for alu_arbiter with a behavioural ALU
//          and an independent arbitration/latency reference model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_alu_arbiter;

    localparam int unsigned MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [2:0]  c [2];

    logic        r0, r1, rv0, rv1, z0, z1;
    logic [31:0] rd0, rd1, ad1, ad2, alu_res;
    logic [2:0]  actl;

    alu_arbiter #(.MUL_LAT(MUL_LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (v[0]),
        .req0_ready_o (r0),
        .req0_data1_i (a[0]),
        .req0_data2_i (b[0]),
        .req0_ctrl_i  (c[0]),
        .req1_valid_i (v[1]),
        .req1_ready_o (r1),
        .req1_data1_i (a[1]),
        .req1_data2_i (b[1]),
        .req1_ctrl_i  (c[1]),
        .resp0_valid_o(rv0),
        .resp0_data_o (rd0),
        .resp0_zero_o (z0),
        .resp1_valid_o(rv1),
        .resp1_data_o (rd1),
        .resp1_zero_o (z1),
        .alu_data1_o  (ad1),
        .alu_data2_o  (ad2),
        .alu_ctrl_o   (actl),
        .alu_data_i   (alu_res)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            3'b000:  return x & y;
            3'b001:  return x ^ y;
            3'b010:  return x + y;
            3'b110:  return x - y;
            3'b111:  return x << y[4:0];
            3'b101:  return 32'($signed(x) >>> y[4:0]);
            3'b011:  return x * y;
            default: return x | y;
        endcase
    endfunction

    // The shared ALU the arbiter drives.
    assign alu_res = ref_alu(actl, ad1, ad2);

    typedef struct {
        logic        who;
        logic [31:0] data;
        logic        zero;
        int          due;
    } exp_t;

    exp_t        sb [$];
    int          dut_hs [$];
    int          cyc      = 0;
    int          m_free   = 0;
    logic        m_last   = 1'b1;
    logic [1:0]  acc      = 2'b00;
    logic [31:0] last_d [2];
    int          compares = 0;
    int          fails    = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        compares++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor (pops on response pulses) followed by the reference model.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_free    = 0;
            m_last    = 1'b1;
            acc       = 2'b00;
            last_d[0] = 32'd0;
            last_d[1] = 32'd0;
        end else begin
            check1("resp_exclusive", rv0 & rv1, 1'b0);
            check1("ready_exclusive", r0 & r1, 1'b0);
            if (rv0 || rv1) begin
                if (sb.size() == 0) begin
                    compares++;
                    fails++;
                    $display("FAIL resp_unexpected: got pulse rv0=%b rv1=%b expected none (cycle %0d)", rv0, rv1, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check1("resp_owner", rv1, e.who);
                    check_int("resp_cycle", cyc, e.due);
                    if (rv1) begin
                        check32("resp1_data", rd1, e.data);
                        check1("resp1_zero", z1, e.zero);
                        check32("resp0_hold", rd0, last_d[0]);
                    end else begin
                        check32("resp0_data", rd0, e.data);
                        check1("resp0_zero", z0, e.zero);
                        check32("resp1_hold", rd1, last_d[1]);
                    end
                    last_d[e.who] = e.data;
                end
            end

            if (r0 && v[0]) dut_hs.push_back(0);
            if (r1 && v[1]) dut_hs.push_back(1);

            begin
                logic idle, e_r0, e_r1;
                idle = (cyc >= m_free);
                e_r0 = idle && v[0] && (!v[1] || m_last);
                e_r1 = idle && v[1] && (!v[0] || !m_last);
                check1("ready0", r0, e_r0);
                check1("ready1", r1, e_r1);
                if (e_r0 || e_r1) begin
                    int          n;
                    int          lat;
                    logic [31:0] res;
                    n   = e_r1 ? 1 : 0;
                    lat = (c[n] == 3'b011) ? int'(MUL_LAT) : 1;
                    res = ref_alu(c[n], a[n], b[n]);
                    sb.push_back('{who: e_r1, data: res, zero: (res == 32'd0), due: cyc + 1 + lat});
                    m_free = cyc + 1 + lat;
                    m_last = e_r1;
                    acc[n] = 1'b1;
                end
            end
        end
    end

    task automatic issue(input int n, input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        v[n] = 1'b1;
        a[n] = x;
        b[n] = y;
        c[n] = op;
    endtask

    task automatic rand_issue(input int n);
        logic [31:0] x;
        logic [31:0] y;
        x = $urandom;
        y = ($urandom_range(0, 3) == 0) ? x : $urandom;
        issue(n, x, y, 3'($urandom_range(0, 7)));
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (acc[n]) begin
                acc[n] = 1'b0;
                v[n]   = 1'b0;
                return;
            end
        end
        compares++;
        fails++;
        $display("FAIL accept_timeout: requester %0d not accepted within 50 cycles", n);
        v[n] = 1'b0;
    endtask

    initial begin
        int count;
        for (int n = 0; n < 2; n++) begin
            v[n] = 1'b0; a[n] = 32'd0; b[n] = 32'd0; c[n] = 3'd0; last_d[n] = 32'd0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check1("rst_rv0", rv0, 1'b0);
        check1("rst_rv1", rv1, 1'b0);
        check32("rst_rd0", rd0, 32'd0);
        check32("rst_rd1", rd1, 32'd0);
        check1("rst_z0", z0, 1'b0);
        check1("rst_z1", z1, 1'b0);
        check32("rst_ad1", ad1, 32'd0);
        check32("rst_ad2", ad2, 32'd0);
        check32("rst_actl", {29'd0, actl}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single ADD on requester 0
        issue(0, 32'd5, 32'd7, 3'b010);
        wait_acc(0);
        @(posedge clk); #1;
        check1("add_rv0", rv0, 1'b1);
        check32("add_rd0", rd0, 32'd12);
        check1("add_z0", z0, 1'b0);
        check1("add_rv1", rv1, 1'b0);

        // SUB to zero on requester 1
        issue(1, 32'd9, 32'd9, 3'b110);
        wait_acc(1);
        @(posedge clk); #1;
        check1("sub_rv1", rv1, 1'b1);
        check32("sub_rd1", rd1, 32'd0);
        check1("sub_z1", z1, 1'b1);

        // MUL latency with operands held on the ALU
        issue(0, 32'hFFFF_FFFD, 32'd4, 3'b011);
        wait_acc(0);
        for (int k = 0; k < int'(MUL_LAT); k++) begin
            if (k != 0) begin
                @(posedge clk); #1;
            end
            check32("mul_ad1", ad1, 32'hFFFF_FFFD);
            check32("mul_ad2", ad2, 32'd4);
            check32("mul_actl", {29'd0, actl}, 32'd3);
            check1("mul_rv0_early", rv0, 1'b0);
        end
        @(posedge clk); #1;
        check1("mul_rv0", rv0, 1'b1);
        check32("mul_rd0", rd0, 32'hFFFF_FFF4);

        // Requester 1 raises valid for one cycle while busy, then withdraws
        issue(0, $urandom, $urandom, 3'b011);
        wait_acc(0);
        issue(1, 32'd1, 32'd2, 3'b010);
        @(posedge clk); #1;
        v[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Reset in the second EXEC cycle of a MUL
        issue(0, 32'hFFFF_FFFD, 32'd4, 3'b011);
        wait_acc(0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check1("mrst_rv0", rv0, 1'b0);
        check32("mrst_rd0", rd0, 32'd0);
        check32("mrst_ad1", ad1, 32'd0);
        check32("mrst_ad2", ad2, 32'd0);
        check32("mrst_actl", {29'd0, actl}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Round-robin under continuous contention, fresh after reset
        dut_hs.delete();
        issue(0, $urandom, $urandom, 3'b010);
        issue(1, $urandom, $urandom, 3'b010);
        count = 0;
        for (int i = 0; i < 40 && count < 4; i++) begin
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) begin
                    acc[n] = 1'b0;
                    count++;
                    if (count < 4) issue(n, $urandom, $urandom, 3'b010);
                end
            end
        end
        v[0] = 1'b0;
        v[1] = 1'b0;
        check_int("rr_count", dut_hs.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_int("rr_order", (i < dut_hs.size()) ? dut_hs[i] : -1, i % 2);
        end
        repeat (4) @(posedge clk);
        #1;

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) begin
                    acc[n] = 1'b0;
                    v[n]   = 1'b0;
                end
                if (!v[n] && $urandom_range(0, 99) < 35) rand_issue(n);
                else if (v[n] && $urandom_range(0, 99) < 4) v[n] = 1'b0;
            end
        end
        v[0] = 1'b0;
        v[1] = 1'b0;

        // Drain outstanding responses
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                @(posedge clk); #1;
                if (sb.size() == 0 && cyc >= m_free) break;
            end
            if (k == 100) begin
                compares++;
                fails++;
                $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
            end
        end
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
`default_nettype wire
